// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output chain.
// Contents:
//   FIR_WIDTH, FIR_DECIM, FIR_FIFO_DEPTH  default sample width, decimation ratio, FIFO depth
//   sample_t                              signed FIR output sample
//   phase_width()                         counter width able to hold 0..decim-1 (min 1 bit)
package fir_pkg;

    localparam int unsigned FIR_WIDTH      = 16;
    localparam int unsigned FIR_DECIM      = 4;
    localparam int unsigned FIR_FIFO_DEPTH = 8;

    typedef logic signed [FIR_WIDTH-1:0] sample_t;

    // A ratio of 1 still needs a 1-bit counter so the keep compare stays well-formed.
    function automatic int unsigned phase_width(input int unsigned decim);
        return (decim > 1) ? $clog2(decim) : 1;
    endfunction

endpackage

// File: rtl/fir_decim_buffer_if.sv
// Stream bundle between the FIR, the decimating buffer and its consumer.
// Signals:
//   in_valid, in_data     filter sample stream into the buffer (no back-pressure)
//   out_valid, out_ready  valid/ready handshake toward the consumer
//   out_data              FIFO head sample
//   fill                  FIFO occupancy, 0..DEPTH
//   overflow, clr_ovf     sticky drop flag and its clear
// Modports:
//   master  producer/consumer side (drives inputs, observes outputs)
//   slave   buffer side
interface fir_decim_buffer_if
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH,
    parameter int unsigned DEPTH = FIR_FIFO_DEPTH
);

    localparam int unsigned FW = $clog2(DEPTH) + 1;

    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic [FW-1:0]           fill;
    logic                    overflow;
    logic                    clr_ovf;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output clr_ovf,
        input  out_valid,
        input  out_data,
        input  fill,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  clr_ovf,
        output out_valid,
        output out_data,
        output fill,
        output overflow
    );

endinterface

// File: rtl/fir_decim_buffer_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst  clock and synchronous active-high reset (flushes pointers and count)
//   push      write wdata at the tail; caller guarantees !full || pop
//   pop       retire the head; caller guarantees valid
//   wdata     sample to write
//   rdata     head entry, forced to 0 while empty
//   valid     FIFO holds at least one entry
//   full      FIFO holds DEPTH entries
//   fill      occupancy, 0..DEPTH
module sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH,
    parameter int unsigned DEPTH = FIR_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic signed [WIDTH-1:0]     wdata,
    output logic signed [WIDTH-1:0]     rdata,
    output logic                        valid,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]           fill_q, fill_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset; the head is masked while empty.
    // On push-while-full with pop, wr_ptr equals rd_ptr: the outgoing head slot is reused.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_comb begin
        valid = (fill_q != '0);
        full  = (fill_q == FW'(DEPTH));
        fill  = fill_q;
        rdata = valid ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: keeps every DECIM-th FIR output sample (the one at index PHASE of each
// group of DECIM valid samples) and buffers it in a DEPTH-entry FWFT FIFO behind a
// valid/ready stream. Kept samples arriving while the FIFO is full and not draining are
// dropped and latch the sticky overflow flag.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset; flushes FIFO, phase and overflow
//   bus  fir_decim_buffer_if.slave: in_valid/in_data in, out_valid/out_ready/out_data out,
//        fill occupancy, overflow flag with clr_ovf clear
// All outputs come from registers; in_* and out_ready only influence next state.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH,
    parameter int unsigned DECIM = FIR_DECIM,
    parameter int unsigned PHASE = 0,
    parameter int unsigned DEPTH = FIR_FIFO_DEPTH
) (
    input logic               clk,
    input logic               rst,
    fir_decim_buffer_if.slave bus
);

    localparam int unsigned     PW         = phase_width(DECIM);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(DECIM - 1);
    localparam logic [PW-1:0]   KEEP_PHASE = PW'(PHASE);

    logic [PW-1:0]           phase_q, phase_d;
    logic                    overflow_q, overflow_d;
    logic                    keep;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    fifo_valid;
    logic                    fifo_full;
    logic signed [WIDTH-1:0] fifo_rdata;
    logic [$clog2(DEPTH):0]  fifo_fill;

    // Phase counts valid samples only, so gaps in in_valid do not shift the kept slot.
    always_comb begin
        phase_d = phase_q;
        if (bus.in_valid) begin
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
        end
    end

    always_comb begin
        keep = bus.in_valid && (phase_q == KEEP_PHASE);
        pop  = fifo_valid && bus.out_ready;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push = keep && (!fifo_full || pop);
        drop = keep && fifo_full && !pop;
    end

    // A drop outranks a simultaneous clear so no lost sample goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .full  (fifo_full),
        .fill  (fifo_fill)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_rdata;
    assign bus.fill      = fifo_fill;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Bench for fir_decim_buffer: vector table, hand-written corner sequences, and a randomized
// run checked against a queue-based reference model.
module tb_fir_decim_buffer;
    import fir_pkg::*;

    localparam int unsigned DEPTH = FIR_FIFO_DEPTH;
    localparam int unsigned DECIM = FIR_DECIM;
    localparam int          NVEC  = 25;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_decim_buffer_if #(.WIDTH(FIR_WIDTH), .DEPTH(DEPTH)) bus ();

    fir_decim_buffer #(
        .WIDTH (FIR_WIDTH),
        .DECIM (DECIM),
        .PHASE (0),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic    rst;
        logic    iv;
        sample_t d;
        logic    rdy;
        logic    ev;
        sample_t ed;
        int      ef;
    } vec_t;

    vec_t vt [NVEC];

    // Reference model state
    sample_t q [$];
    int      nvalid;
    logic    movf;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic iv, input sample_t d, input logic rdy,
                       input logic clr);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic r, input logic iv, input int d, input logic rdy,
                                 input logic ev, input int ed, input int ef);
        vec_t v;
        v.rst = r;
        v.iv  = iv;
        v.d   = sample_t'(d);
        v.rdy = rdy;
        v.ev  = ev;
        v.ed  = sample_t'(ed);
        v.ef  = ef;
        return v;
    endfunction

    // One clock of the model, evaluated from the state seen before the edge.
    function automatic void model_step(input logic r, input logic iv, input sample_t d,
                                       input logic rdy, input logic clr);
        logic drop;
        if (r) begin
            q.delete();
            nvalid = 0;
            movf   = 1'b0;
            return;
        end
        drop = 1'b0;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (iv && (nvalid % DECIM) == 0) begin
            if (q.size() < DEPTH) q.push_back(d);
            else drop = 1'b1;
        end
        if (drop) movf = 1'b1;
        else if (clr) movf = 1'b0;
        if (iv) nvalid++;
    endfunction

    task automatic drain_expect(input string tag, input int first, input int n);
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_head%0d", tag, j), bus.out_data, first + 4 * j);
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        check({tag, "_empty_valid"}, bus.out_valid, 0);
        check({tag, "_empty_fill"}, bus.fill, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;

        // Reset, ramp 0..7 with ready, then ramp 0..7 on alternate valid cycles.
        vt[0]  = mkv(1, 0, 0, 0, 0, 0, 0);
        vt[1]  = mkv(0, 1, 0, 1, 1, 0, 1);
        vt[2]  = mkv(0, 1, 1, 1, 0, 0, 0);
        vt[3]  = mkv(0, 1, 2, 1, 0, 0, 0);
        vt[4]  = mkv(0, 1, 3, 1, 0, 0, 0);
        vt[5]  = mkv(0, 1, 4, 1, 1, 4, 1);
        vt[6]  = mkv(0, 1, 5, 1, 0, 0, 0);
        vt[7]  = mkv(0, 1, 6, 1, 0, 0, 0);
        vt[8]  = mkv(0, 1, 7, 1, 0, 0, 0);
        vt[9]  = mkv(0, 1, 0, 1, 1, 0, 1);
        vt[10] = mkv(0, 0, 32767, 1, 0, 0, 0);
        vt[11] = mkv(0, 1, 1, 1, 0, 0, 0);
        vt[12] = mkv(0, 0, 32767, 1, 0, 0, 0);
        vt[13] = mkv(0, 1, 2, 1, 0, 0, 0);
        vt[14] = mkv(0, 0, 32767, 1, 0, 0, 0);
        vt[15] = mkv(0, 1, 3, 1, 0, 0, 0);
        vt[16] = mkv(0, 0, 32767, 1, 0, 0, 0);
        vt[17] = mkv(0, 1, 4, 1, 1, 4, 1);
        vt[18] = mkv(0, 0, 32767, 1, 0, 0, 0);
        vt[19] = mkv(0, 1, 5, 1, 0, 0, 0);
        vt[20] = mkv(0, 0, 32767, 1, 0, 0, 0);
        vt[21] = mkv(0, 1, 6, 1, 0, 0, 0);
        vt[22] = mkv(0, 0, 32767, 1, 0, 0, 0);
        vt[23] = mkv(0, 1, 7, 1, 0, 0, 0);
        vt[24] = mkv(0, 0, 32767, 1, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            cyc(vt[i].rst, vt[i].iv, vt[i].d, vt[i].rdy, 1'b0);
            check($sformatf("tbl%0d_valid", i), bus.out_valid, vt[i].ev);
            if (vt[i].ev || vt[i].rst) begin
                check($sformatf("tbl%0d_data", i), bus.out_data, vt[i].ed);
            end
            check($sformatf("tbl%0d_fill", i), bus.fill, vt[i].ef);
            check($sformatf("tbl%0d_ovf", i), bus.overflow, 0);
        end

        // Saturate with out_ready low, then overflow on sample 32.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) cyc(1'b0, 1'b1, sample_t'(k), 1'b0, 1'b0);
        check("sat_fill", bus.fill, 8);
        check("sat_head", bus.out_data, 0);
        check("sat_valid", bus.out_valid, 1);
        check("sat_ovf", bus.overflow, 0);
        cyc(1'b0, 1'b1, sample_t'(32), 1'b0, 1'b0);
        check("drop_ovf", bus.overflow, 1);
        for (int k = 33; k < 36; k++) cyc(1'b0, 1'b1, sample_t'(k), 1'b0, 1'b0);
        check("drop_fill", bus.fill, 8);
        check("drop_head", bus.out_data, 0);

        // Clear coinciding with a drop keeps the flag; a lone clear releases it.
        cyc(1'b0, 1'b1, sample_t'(36), 1'b0, 1'b1);
        check("clr_vs_drop_ovf", bus.overflow, 1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("clr_alone_ovf", bus.overflow, 0);
        drain_expect("drain_a", 0, 8);

        // Full FIFO, keep and pop in one cycle: push accepted, no overflow.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) cyc(1'b0, 1'b1, sample_t'(k), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, sample_t'(32), 1'b1, 1'b0);
        check("fullpop_fill", bus.fill, 8);
        check("fullpop_ovf", bus.overflow, 0);
        drain_expect("drain_b", 4, 8);

        // Mid-stream reset with fill=5 and phase=2; inputs during reset are ignored.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 18; k++) cyc(1'b0, 1'b1, sample_t'(k), 1'b0, 1'b0);
        check("prerst_fill", bus.fill, 5);
        cyc(1'b1, 1'b1, sample_t'(77), 1'b1, 1'b1);
        check("rst_fill", bus.fill, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ovf", bus.overflow, 0);
        cyc(1'b0, 1'b1, sample_t'(-100), 1'b0, 1'b0);
        check("postrst_valid", bus.out_valid, 1);
        check("postrst_data", bus.out_data, -100);
        for (int k = 1; k < 4; k++) cyc(1'b0, 1'b1, sample_t'(k), 1'b0, 1'b0);
        check("postrst_skip_fill", bus.fill, 1);
        cyc(1'b0, 1'b1, sample_t'(104), 1'b0, 1'b0);
        check("postrst_keep_fill", bus.fill, 2);

        // Randomized run against the model.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        begin
            int rdy_pct;
            rdy_pct = 50;
            for (int c = 0; c < 4000; c++) begin
                logic    r, iv, rdy, clr;
                sample_t d;
                if (c % 500 == 0) rdy_pct = $urandom_range(5, 95);
                r   = ($urandom_range(0, 299) == 0);
                iv  = ($urandom_range(0, 9) < 7);
                d   = sample_t'($urandom);
                rdy = ($urandom_range(0, 99) < rdy_pct);
                clr = ($urandom_range(0, 19) == 0);
                model_step(r, iv, d, rdy, clr);
                cyc(r, iv, d, rdy, clr);
                check($sformatf("rnd%0d_valid", c), bus.out_valid, (q.size() != 0));
                check($sformatf("rnd%0d_fill", c), bus.fill, q.size());
                check($sformatf("rnd%0d_ovf", c), bus.overflow, movf);
                if (q.size() != 0) check($sformatf("rnd%0d_data", c), bus.out_data, q[0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
